// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one FP multiplier core between two requesters.
// Optional BUSY watchdog enabled by defining FPARB_TIMEOUT_EN.
module fp_mult_arbiter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             ack0,
  output logic             resValid0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack1,
  output logic             resValid1,
  output logic [WIDTH-1:0] res,
  output logic             timeout,
  output logic [WIDTH-1:0] fpA,
  output logic [WIDTH-1:0] fpB,
  output logic             fpStart,
  input  logic             fpDone,
  input  logic [WIDTH-1:0] fpResult,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_ISSUE   = 4'b0010,
    S_BUSY    = 4'b0100,
    S_DELIVER = 4'b1000
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_fpa;
  logic [WIDTH-1:0] r_fpb;
  logic [WIDTH-1:0] r_res;
  logic             w_grant;
  logic             w_owner_sel;
  logic             w_to_hit;

  // Round-robin pick: a tie goes to the port that did not win last time
  always_comb begin
    w_grant     = req0 | req1;
    w_owner_sel = (req0 & req1) ? ~r_last_grant : req1;
  end

`ifdef FPARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_to;

  // A done arriving on the limit cycle takes priority over the abort
  always_comb begin
    w_cnt_inc = r_cnt + CNT_W'(1);
    w_to_hit  = (r_state == S_BUSY) && !fpDone &&
                (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= w_cnt_inc;
      r_to  <= w_to_hit;
    end
  end
`else
  logic w_unused_timeout;

  always_comb begin
    w_to_hit         = 1'b0;
    w_unused_timeout = (TIMEOUT_CYCLES == 0);
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_BUSY;
      S_BUSY:    if (fpDone || w_to_hit) w_state_nxt = S_DELIVER;
      S_DELIVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at grant, result capture while waiting on the core
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_fpa        <= '0;
      r_fpb        <= '0;
      r_res        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner      <= w_owner_sel;
            r_last_grant <= w_owner_sel;
            r_fpa        <= w_owner_sel ? a1 : a0;
            r_fpb        <= w_owner_sel ? b1 : b0;
          end
        end
        S_BUSY: begin
          if (fpDone) begin
            r_res <= fpResult;
          end else if (w_to_hit) begin
            r_res <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    resValid0 = 1'b0;
    resValid1 = 1'b0;
    fpStart   = 1'b0;
    timeout   = 1'b0;
    busy      = (r_state != S_IDLE);
    fpA       = r_fpa;
    fpB       = r_fpb;
    res       = r_res;
    if (r_state == S_ISSUE) begin
      fpStart = 1'b1;
      ack0    = ~r_owner;
      ack1    = r_owner;
    end
    if (r_state == S_DELIVER) begin
      resValid0 = ~r_owner;
      resValid1 = r_owner;
`ifdef FPARB_TIMEOUT_EN
      timeout   = r_to;
`endif
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter: cycle-level reference model,
// bench-owned multiplier core and directed scenarios with literal expectations.
module tb_fp_mult_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;
`ifdef FPARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, resValid0, resValid1, timeout, fpStart, busy;
  logic [W-1:0] res, fpA, fpB;
  logic         core_done = 1'b0, stray_done = 1'b0;
  logic [W-1:0] core_res = '0, stray_val = '0;
  logic         fpDone;
  logic [W-1:0] fpResult;

  assign fpDone   = core_done | stray_done;
  assign fpResult = stray_done ? stray_val : core_res;

  fp_mult_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .resValid0(resValid0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .resValid1(resValid1),
    .res(res), .timeout(timeout), .fpA(fpA), .fpB(fpB), .fpStart(fpStart),
    .fpDone(fpDone), .fpResult(fpResult), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Known IEEE-754 products; anything else returns an arbitrary tag
  function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] k;
    k = {a, b};
    case (k)
      64'h40000000_40400000: prod = 32'h40C00000;
      64'h3FC00000_40000000: prod = 32'h40400000;
      64'h40800000_3F000000: prod = 32'h40000000;
      64'hC0000000_40400000: prod = 32'hC0C00000;
      default:               prod = a ^ b;
    endcase
  endfunction

  // Multiplier core: done pulse core_lat cycles after the start cycle
  int           core_lat = 3;
  bit           core_mute = 1'b0;
  int           core_cnt = 0;
  logic [W-1:0] core_pend = '0;
  always begin
    @(negedge clk);
    if (fpStart && !core_mute) begin
      core_cnt  = core_lat;
      core_pend = prod(fpA, fpB);
    end
    @(posedge clk);
    #1;
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_res  = core_pend;
      end
    end
  end

  // Reference model: transaction in flight, its phase, and the shared result
  bit           m_ready = 1'b0, m_busy = 1'b0, m_issue = 1'b0, m_deliver = 1'b0;
  bit           m_owner = 1'b0, m_last = 1'b1, m_to = 1'b0;
  int           m_wait = 0;
  logic [W-1:0] m_res = '0, m_fpa = '0, m_fpb = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1; m_busy = 1'b0; m_issue = 1'b0; m_deliver = 1'b0;
      m_owner = 1'b0; m_last = 1'b1; m_to = 1'b0;
      m_res = '0; m_fpa = '0; m_fpb = '0;
    end else if (!m_busy) begin
      if (req0 || req1) begin
        m_owner = (req0 && req1) ? !m_last : req1;
        m_last  = m_owner;
        m_fpa   = m_owner ? a1 : a0;
        m_fpb   = m_owner ? b1 : b0;
        m_busy  = 1'b1;
        m_issue = 1'b1;
      end
    end else if (m_issue) begin
      m_issue = 1'b0;
      m_wait  = 0;
    end else if (m_deliver) begin
      m_deliver = 1'b0;
      m_busy    = 1'b0;
    end else begin
      m_wait++;
      if (fpDone) begin
        m_res = fpResult; m_to = 1'b0; m_deliver = 1'b1;
      end else if (TO_EN && m_wait == int'(TO)) begin
        m_res = '0; m_to = 1'b1; m_deliver = 1'b1;
      end
    end
  end

  int ackq[$];
  bit rec = 1'b0;

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ready) begin
      check1("ack0", ack0, m_issue && !m_owner);
      check1("ack1", ack1, m_issue && m_owner);
      check1("fpStart", fpStart, m_issue);
      check1("resValid0", resValid0, m_deliver && !m_owner);
      check1("resValid1", resValid1, m_deliver && m_owner);
      check1("timeout", timeout, m_deliver && m_to);
      check1("busy", busy, m_busy);
      check("res", res, m_res);
      check("fpA", fpA, m_fpa);
      check("fpB", fpB, m_fpb);
    end
    if (rec) begin
      if (ack0) ackq.push_back(0);
      if (ack1) ackq.push_back(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       sel = ack0;
      1:       sel = ack1;
      2:       sel = resValid0;
      3:       sel = resValid1;
      default: sel = !busy;
    endcase
  endfunction

  task automatic wait_for(input int which, input int max_cyc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (sel(which)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=not_seen required=seen_within_%0d_cycles", name, max_cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1, "bench watchdog expired");
  end

  int c0, cr;
  int exp2[4] = '{0, 1, 0, 1};

  initial begin
    repeat (2) step();
    rst = 1'b0;
    step();

    // Tie after reset, both held: strict alternation starting at port 0
    a0 = 32'h40000000; b0 = 32'h40400000;
    a1 = 32'h3FC00000; b1 = 32'h40000000;
    rec = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (ackq.size() >= 4) break;
    end
    req0 = 1'b0; req1 = 1'b0; rec = 1'b0;
    wait_for(4, 30, "t2_idle");
    check("t2_ack_count", ackq.size(), 4);
    if (ackq.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t2_ack_order", ackq[i], exp2[i]);
    end

    // Single request, 2.0 * 3.0
    step();
    a0 = 32'h40000000; b0 = 32'h40400000; req0 = 1'b1; c0 = cyc;
    wait_for(0, 4, "t1_ack0");
    check("t1_ack_latency", cyc - c0, 1);
    check("t1_fpA", fpA, 32'h40000000);
    check("t1_fpB", fpB, 32'h40400000);
    req0 = 1'b0;
    wait_for(2, 20, "t1_rv0");
    check("t1_rv_latency", cyc - c0, 5);
    check("t1_res", res, 32'h40C00000);
    wait_for(4, 5, "t1_idle");

    // Request from port 1 arrives while port 0 is busy
    core_lat = 5;
    a0 = 32'h3FC00000; b0 = 32'h40000000; req0 = 1'b1;
    wait_for(0, 4, "t3_ack0");
    req0 = 1'b0;
    step(); step();
    a1 = 32'h40800000; b1 = 32'h3F000000; req1 = 1'b1;
    wait_for(2, 20, "t3_rv0");
    cr = cyc;
    check("t3_res0", res, 32'h40400000);
    wait_for(1, 6, "t3_ack1");
    check("t3_ack1_latency", cyc - cr, 2);
    req1 = 1'b0;
    wait_for(3, 20, "t3_rv1");
    check("t3_res1", res, 32'h40000000);
    wait_for(4, 5, "t3_idle");

    // Stray done in IDLE and in ISSUE
    core_lat = 3;
    step();
    stray_val = 32'hDEADBEEF; stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    check1("t4_idle_rv0", resValid0, 1'b0);
    check1("t4_idle_busy", busy, 1'b0);
    step();
    check("t4_idle_res", res, 32'h40000000);
    a0 = 32'hC0000000; b0 = 32'h40400000; req0 = 1'b1; c0 = cyc;
    wait_for(0, 4, "t4_ack0");
    stray_done = 1'b1; req0 = 1'b0;
    step();
    stray_done = 1'b0;
    check1("t4_busy_after_issue", busy, 1'b1);
    wait_for(2, 20, "t4_rv0");
    check("t4_rv_latency", cyc - c0, 5);
    check("t4_res", res, 32'hC0C00000);
    wait_for(4, 5, "t4_idle");

    // Reset during BUSY, then a late done from the abandoned operation
    core_lat = 6;
    a0 = 32'h40000000; b0 = 32'h40400000; req0 = 1'b1;
    wait_for(0, 4, "t5_ack0");
    req0 = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("t5_ack0", ack0, 1'b0);
    check1("t5_ack1", ack1, 1'b0);
    check1("t5_rv0", resValid0, 1'b0);
    check1("t5_rv1", resValid1, 1'b0);
    check1("t5_timeout", timeout, 1'b0);
    check1("t5_fpStart", fpStart, 1'b0);
    check1("t5_busy", busy, 1'b0);
    check("t5_res", res, 32'h0);
    check("t5_fpA", fpA, 32'h0);
    check("t5_fpB", fpB, 32'h0);
    repeat (6) step();
    check("t5_res_after_late_done", res, 32'h0);
    check1("t5_busy_after_late_done", busy, 1'b0);
    core_lat = 3;
    a0 = 32'h3FC00000; b0 = 32'h40000000; req0 = 1'b1; c0 = cyc;
    wait_for(0, 4, "t5_ack0_again");
    check("t5_ack_latency", cyc - c0, 1);
    req0 = 1'b0;
    wait_for(2, 20, "t5_rv0");
    check("t5_res_new", res, 32'h40400000);
    wait_for(4, 5, "t5_idle");

    // Core never answers
    core_mute = 1'b1;
    a0 = 32'h40000000; b0 = 32'h40400000; req0 = 1'b1;
    wait_for(0, 4, "t6_ack0");
    c0 = cyc;
    req0 = 1'b0;
`ifdef FPARB_TIMEOUT_EN
    wait_for(2, 30, "t6_rv0");
    check("t6_abort_latency", cyc - c0, 9);
    check1("t6_timeout", timeout, 1'b1);
    check("t6_res", res, 32'h0);
    step();
    check1("t6_idle", busy, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      check1("t6_busy_hold", busy, 1'b1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("t6_busy_after_reset", busy, 1'b0);
`endif
    core_mute = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
